dmem_lsu: RTL and testbench

Load/store initiator sitting between the core's execute stage and the data memory port: it accepts one load or store request at a time over a valid/ready handshake, drives the memory's `addr`/`din`/`memOp`/`we` port, captures read data, and returns one response per request. Aligned accesses pass through as a single memory operation. Misaligned halfword and word accesses are optionally split into byte operations and reassembled, since the data memory only honours naturally aligned halfword and word accesses.

---
 rtl/dmem_lsu.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the execute stage and the data memory.
// One request at a time; aligned accesses become a single memory operation.
// Build option DMEM_LSU_SPLIT_EN: when defined, misaligned halfword/word accesses
// are split into byte operations and reassembled. When undefined, they are rejected
// with rspErr and never reach the memory.
module dmem_lsu #(
   parameter int addrWidth = 32,
   parameter int dataWidth = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 reqValid,
   output logic                 reqReady,
   input  logic                 reqWe,
   input  logic [2:0]           reqOp,
   input  logic [addrWidth-1:0] reqAddr,
   input  logic [dataWidth-1:0] reqData,
   output logic                 rspValid,
   input  logic                 rspReady,
   output logic [dataWidth-1:0] rspData,
   output logic                 rspErr,
   output logic [addrWidth-1:0] memAddr,
   output logic [dataWidth-1:0] memDin,
   output logic [2:0]           memOp,
   output logic                 memWe,
   input  logic [dataWidth-1:0] memDout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t               state;
   logic [2:0]           op_q;
   logic                 we_q;
   logic [addrWidth-1:0] addr_q;
   logic [dataWidth-1:0] data_q;
   logic [1:0]           idx;
   logic [1:0]           last;
   logic                 byte_mode;
   logic [dataWidth-1:0] asm_q;

   logic [2:0]           req_op_norm;
   logic [1:0]           req_mask;
   logic                 req_misaligned;
   logic [1:0]           idx_inc;
   logic [addrWidth-1:0] addr_inc;
   logic [dataWidth-1:0] din_inc;
   logic [dataWidth-1:0] asm_ins;
   logic [dataWidth-1:0] asm_ext;

   // Decode the incoming request: fold the undefined op codes onto LW, derive the size mask and alignment.
   always_comb begin
      req_op_norm = reqOp;
      if (reqOp == 3'd3 || reqOp == 3'd6 || reqOp == 3'd7) begin
         req_op_norm = 3'd2;
      end
      case (req_op_norm)
         3'd0, 3'd4: req_mask = 2'd0;
         3'd1, 3'd5: req_mask = 2'd1;
         default:    req_mask = 2'd3;
      endcase
      req_misaligned = (reqAddr[1:0] & req_mask) != 2'd0;
   end

   // Byte-mode helpers: next byte's address/data, byte insertion into the assembly register, final extension.
   always_comb begin
      idx_inc        = idx + 2'd1;
      addr_inc       = addr_q + addrWidth'(idx_inc);
      din_inc        = '0;
      din_inc[7:0]   = data_q[8*idx_inc +: 8];
      asm_ins        = asm_q;
      asm_ins[8*idx +: 8] = memDout[7:0];
      case (op_q)
         3'd1:    asm_ext = {{16{asm_ins[15]}}, asm_ins[15:0]};
         3'd5:    asm_ext = {16'b0, asm_ins[15:0]};
         default: asm_ext = asm_ins;
      endcase
   end

   // Request FSM with registered handshake and memory-port outputs; the port idles at addr 0 / op LW.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         reqReady  <= 1'b1;
         rspValid  <= 1'b0;
         rspData   <= '0;
         rspErr    <= 1'b0;
         memWe     <= 1'b0;
         memAddr   <= '0;
         memDin    <= '0;
         memOp     <= 3'd2;
         idx       <= 2'd0;
         last      <= 2'd0;
         asm_q     <= '0;
         op_q      <= 3'd2;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         byte_mode <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (reqValid && reqReady) begin
                  op_q     <= req_op_norm;
                  we_q     <= reqWe;
                  addr_q   <= reqAddr;
                  data_q   <= reqData;
                  idx      <= 2'd0;
                  asm_q    <= '0;
                  reqReady <= 1'b0;
                  if (!req_misaligned) begin
                     state     <= ISSUE;
                     byte_mode <= 1'b0;
                     last      <= 2'd0;
                     memAddr   <= reqAddr;
                     memOp     <= req_op_norm;
                     memDin    <= reqData;
                     memWe     <= reqWe;
                  end else begin
`ifdef DMEM_LSU_SPLIT_EN
                     state     <= ISSUE;
                     byte_mode <= 1'b1;
                     last      <= req_mask;
                     memAddr   <= reqAddr;
                     memOp     <= reqWe ? 3'd0 : 3'd4;
                     memDin    <= dataWidth'(reqData[7:0]);
                     memWe     <= reqWe;
`else
                     state     <= RESP;
                     rspValid  <= 1'b1;
                     rspErr    <= 1'b1;
                     rspData   <= '0;
`endif
                  end
               end
            end
            ISSUE: begin
               if (we_q) begin
                  idx <= idx_inc;
                  if (idx == last) begin
                     state    <= RESP;
                     rspValid <= 1'b1;
                     rspErr   <= 1'b0;
                     rspData  <= '0;
                     memWe    <= 1'b0;
                     memAddr  <= '0;
                     memDin   <= '0;
                     memOp    <= 3'd2;
                  end else begin
                     memAddr <= addr_inc;
                     memDin  <= din_inc;
                  end
               end else begin
                  state   <= CAPT;
                  memWe   <= 1'b0;
                  memAddr <= '0;
                  memDin  <= '0;
                  memOp   <= 3'd2;
               end
            end
            CAPT: begin
               if (!byte_mode) begin
                  asm_q    <= memDout;
                  rspData  <= memDout;
                  state    <= RESP;
                  rspValid <= 1'b1;
                  rspErr   <= 1'b0;
               end else begin
                  asm_q <= asm_ins;
                  idx   <= idx_inc;
                  if (idx == last) begin
                     rspData  <= asm_ext;
                     state    <= RESP;
                     rspValid <= 1'b1;
                     rspErr   <= 1'b0;
                  end else begin
                     state   <= ISSUE;
                     memAddr <= addr_inc;
                     memOp   <= 3'd4;
                     memDin  <= din_inc;
                     memWe   <= 1'b0;
                  end
               end
            end
            RESP: begin
               if (rspReady) begin
                  state    <= IDLE;
                  rspValid <= 1'b0;
                  rspErr   <= 1'b0;
                  reqReady <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: byte-array data memory model, directed vector table,
// split/reset corner sequences and randomized traffic against a reference model.
// Expectations follow the DMEM_LSU_SPLIT_EN build option.
module tb_dmem_lsu;

`ifdef DMEM_LSU_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic        reqWe = 1'b0;
   logic [2:0]  reqOp = 3'd0;
   logic [31:0] reqAddr = 32'd0;
   logic [31:0] reqData = 32'd0;
   logic        rspValid;
   logic        rspReady = 1'b0;
   logic [31:0] rspData;
   logic        rspErr;
   logic [31:0] memAddr;
   logic [31:0] memDin;
   logic [2:0]  memOp;
   logic        memWe;
   logic [31:0] memDout = 32'd0;

   int checks = 0;
   int passes = 0;

   typedef struct {
      bit [31:0] addr;
      bit [31:0] din;
      bit [2:0]  op;
      bit        we;
   } memop_t;
   memop_t oplog[$];

   typedef struct {
      bit        we;
      bit [2:0]  op;
      bit [31:0] addr;
      bit [31:0] data;
      int        hold;
      bit [31:0] expData;
      bit        expErr;
      int        expLat;
      int        expOps;
   } vec_t;
   vec_t vecs[$];

   bit [7:0] mem    [bit [31:0]];
   bit [7:0] refmem [bit [31:0]];
   bit [31:0] memRaw;
   int        memN;

   dmem_lsu #(.addrWidth(32), .dataWidth(32)) dut (
      .clk(clk), .rstn(rstn),
      .reqValid(reqValid), .reqReady(reqReady), .reqWe(reqWe), .reqOp(reqOp),
      .reqAddr(reqAddr), .reqData(reqData),
      .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
      .memAddr(memAddr), .memDin(memDin), .memOp(memOp), .memWe(memWe), .memDout(memDout)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic int sizeOf(input bit [2:0] op);
      if (op == 3'd0 || op == 3'd4) return 1;
      if (op == 3'd1 || op == 3'd5) return 2;
      return 4;
   endfunction

   function automatic bit [31:0] extend(input bit [31:0] raw, input bit [2:0] op);
      case (op)
         3'd0:    return {{24{raw[7]}}, raw[7:0]};
         3'd4:    return {24'b0, raw[7:0]};
         3'd1:    return {{16{raw[15]}}, raw[15:0]};
         3'd5:    return {16'b0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   function automatic bit [7:0] rdb(input bit [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   function automatic bit [7:0] refRd(input bit [31:0] a);
      return refmem.exists(a) ? refmem[a] : 8'h00;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // Data memory model: logs every issued operation, writes on memWe, registers extended read data.
   always @(posedge clk) begin
      memN = sizeOf(memOp);
      if (rstn && (memWe || memAddr != 32'd0 || memOp != 3'd2 || memDin != 32'd0)) begin
         oplog.push_back('{memAddr, memDin, memOp, memWe});
         checkOutput("mem.aligned", memAddr % 32'(memN), 32'd0);
      end
      memRaw = {rdb(memAddr + 32'd3), rdb(memAddr + 32'd2), rdb(memAddr + 32'd1), rdb(memAddr)};
      if (memWe) begin
         for (int i = 0; i < memN; i++) mem[memAddr + 32'(i)] = memDin[8*i +: 8];
      end
      memDout <= extend(memRaw, memOp);
   end

   // Reference model: outcome of one request derived from size, alignment and byte-array memory contents.
   task automatic refModel(input bit we, input bit [2:0] op, input bit [31:0] addr, input bit [31:0] data,
                           output bit [31:0] d, output bit e, output int lat, output int nops);
      int n;
      bit mis;
      bit [31:0] raw;
      n   = sizeOf((op == 3'd3 || op == 3'd6 || op == 3'd7) ? 3'd2 : op);
      mis = (addr % 32'(n)) != 32'd0;
      if (mis && !SPLIT) begin
         d = 32'd0; e = 1'b0 | 1'b1; lat = 1; nops = 0;
         return;
      end
      e    = 1'b0;
      nops = mis ? n : 1;
      if (we) begin
         for (int i = 0; i < n; i++) refmem[addr + 32'(i)] = data[8*i +: 8];
         d   = 32'd0;
         lat = mis ? n + 1 : 2;
      end else begin
         raw = 32'd0;
         for (int i = 0; i < n; i++) raw[8*i +: 8] = refRd(addr + 32'(i));
         d   = extend(raw, op);
         lat = mis ? 2 * n + 1 : 3;
      end
   endtask

   function automatic vec_t mkVec(input bit we, input bit [2:0] op, input bit [31:0] addr, input bit [31:0] data,
                                  input int hold, input bit [31:0] expData, input bit expErr,
                                  input int expLat, input int expOps);
      vec_t v;
      v.we = we; v.op = op; v.addr = addr; v.data = data; v.hold = hold;
      v.expData = expData; v.expErr = expErr; v.expLat = expLat; v.expOps = expOps;
      return v;
   endfunction

   // One full request/response transaction with latency, stability and handshake checks.
   task automatic applyStimulus(input string tag, input bit we, input bit [2:0] op, input bit [31:0] addr,
                                input bit [31:0] data, input int hold, input bit [31:0] expData,
                                input bit expErr, input int expLat, input int expOps);
      int lat;
      @(negedge clk);
      checkOutput({tag, ".reqReady"}, 32'(reqReady), 32'd1);
      checkOutput({tag, ".idleValid"}, 32'(rspValid), 32'd0);
      reqValid = 1'b1; reqWe = we; reqOp = op; reqAddr = addr; reqData = data;
      oplog.delete();
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      lat = 1;
      while (rspValid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, ".rspData"}, rspData, expData);
      checkOutput({tag, ".rspErr"}, 32'(rspErr), 32'(expErr));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput({tag, ".holdValid"}, 32'(rspValid), 32'd1);
         checkOutput({tag, ".holdData"}, rspData, expData);
         checkOutput({tag, ".holdErr"}, 32'(rspErr), 32'(expErr));
         checkOutput({tag, ".holdWe"}, 32'(memWe), 32'd0);
         checkOutput({tag, ".holdReady"}, 32'(reqReady), 32'd0);
      end
      checkOutput({tag, ".memOps"}, 32'(oplog.size()), 32'(expOps));
      rspReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rspReady = 1'b0;
      checkOutput({tag, ".doneValid"}, 32'(rspValid), 32'd0);
      checkOutput({tag, ".doneReady"}, 32'(reqReady), 32'd1);
   endtask

   // Abort guard so the bench always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Main test sequence.
   initial begin
      bit        w;
      bit [2:0]  o;
      bit [31:0] a, d, ed;
      bit        ee;
      int        el, eo, h;

      mem[32'h100] = 8'hBB; mem[32'h101] = 8'hAA; mem[32'h102] = 8'h99; mem[32'h103] = 8'h88;

      vecs.push_back(mkVec(1'b0, 3'd2, 32'h100, 32'h0,        0, 32'h8899AABB, 1'b0, 3, 1));
      vecs.push_back(mkVec(1'b1, 3'd1, 32'h202, 32'hFFFF1234, 1, 32'h0,        1'b0, 2, 1));
      vecs.push_back(mkVec(1'b0, 3'd5, 32'h202, 32'h0,        0, 32'h00001234, 1'b0, 3, 1));
      vecs.push_back(mkVec(1'b0, 3'd1, 32'h102, 32'h0,        0, 32'hFFFF8899, 1'b0, 3, 1));
      vecs.push_back(mkVec(1'b0, 3'd0, 32'h101, 32'h0,        0, 32'hFFFFFFAA, 1'b0, 3, 1));
      vecs.push_back(mkVec(1'b0, 3'd4, 32'h101, 32'h0,        2, 32'h000000AA, 1'b0, 3, 1));
      vecs.push_back(mkVec(1'b1, 3'd0, 32'h103, 32'hFFFFFF80, 0, 32'h0,        1'b0, 2, 1));
      vecs.push_back(mkVec(1'b1, 3'd0, 32'h104, 32'h000000FF, 0, 32'h0,        1'b0, 2, 1));
`ifdef DMEM_LSU_SPLIT_EN
      vecs.push_back(mkVec(1'b0, 3'd1, 32'h103, 32'h0,        2, 32'hFFFFFF80, 1'b0, 5, 2));
      vecs.push_back(mkVec(1'b0, 3'd2, 32'h102, 32'h0,        3, 32'h00FF8099, 1'b0, 9, 4));
      vecs.push_back(mkVec(1'b1, 3'd2, 32'h301, 32'hDEADBEEF, 0, 32'h0,        1'b0, 5, 4));
      vecs.push_back(mkVec(1'b0, 3'd2, 32'h300, 32'h0,        0, 32'hADBEEF00, 1'b0, 3, 1));
      vecs.push_back(mkVec(1'b0, 3'd5, 32'h203, 32'h0,        0, 32'h00000012, 1'b0, 5, 2));
`else
      vecs.push_back(mkVec(1'b0, 3'd1, 32'h103, 32'h0,        2, 32'h0,        1'b1, 1, 0));
      vecs.push_back(mkVec(1'b0, 3'd2, 32'h102, 32'h0,        3, 32'h0,        1'b1, 1, 0));
      vecs.push_back(mkVec(1'b1, 3'd2, 32'h301, 32'hDEADBEEF, 0, 32'h0,        1'b1, 1, 0));
      vecs.push_back(mkVec(1'b0, 3'd2, 32'h300, 32'h0,        0, 32'h0,        1'b0, 3, 1));
      vecs.push_back(mkVec(1'b0, 3'd5, 32'h203, 32'h0,        0, 32'h0,        1'b1, 1, 0));
`endif
      vecs.push_back(mkVec(1'b0, 3'd3, 32'h100, 32'h0,        0, 32'h8099AABB, 1'b0, 3, 1));

      #2 rstn = 1'b0;
      #1;
      checkOutput("reset.reqReady", 32'(reqReady), 32'd1);
      checkOutput("reset.rspValid", 32'(rspValid), 32'd0);
      checkOutput("reset.rspData",  rspData, 32'd0);
      checkOutput("reset.rspErr",   32'(rspErr), 32'd0);
      checkOutput("reset.memWe",    32'(memWe), 32'd0);
      checkOutput("reset.memAddr",  memAddr, 32'd0);
      checkOutput("reset.memDin",   memDin, 32'd0);
      checkOutput("reset.memOp",    32'(memOp), 32'd2);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].data,
                       vecs[i].hold, vecs[i].expData, vecs[i].expErr, vecs[i].expLat, vecs[i].expOps);
      end

`ifdef DMEM_LSU_SPLIT_EN
      applyStimulus("splitLH", 1'b0, 3'd1, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0, 5, 2);
      for (int i = 0; i < 2 && i < oplog.size(); i++) begin
         checkOutput($sformatf("splitLH.addr%0d", i), oplog[i].addr, 32'h103 + 32'(i));
         checkOutput($sformatf("splitLH.op%0d", i), 32'(oplog[i].op), 32'd4);
         checkOutput($sformatf("splitLH.we%0d", i), 32'(oplog[i].we), 32'd0);
      end
      applyStimulus("splitSW", 1'b1, 3'd2, 32'h301, 32'hDEADBEEF, 1, 32'h0, 1'b0, 5, 4);
      d = 32'hDEADBEEF;
      for (int i = 0; i < 4 && i < oplog.size(); i++) begin
         checkOutput($sformatf("splitSW.addr%0d", i), oplog[i].addr, 32'h301 + 32'(i));
         checkOutput($sformatf("splitSW.din%0d", i), oplog[i].din, {24'b0, d[8*i +: 8]});
         checkOutput($sformatf("splitSW.op%0d", i), 32'(oplog[i].op), 32'd0);
         checkOutput($sformatf("splitSW.we%0d", i), 32'(oplog[i].we), 32'd1);
      end

      @(negedge clk);
      reqValid = 1'b1; reqWe = 1'b1; reqOp = 3'd2; reqAddr = 32'h301; reqData = 32'hCAFEF00D;
      oplog.delete();
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      checkOutput("abort.secondWe", 32'(memWe), 32'd1);
      checkOutput("abort.secondAddr", memAddr, 32'h302);
      rstn = 1'b0;
      #1;
      checkOutput("abort.memWe", 32'(memWe), 32'd0);
      checkOutput("abort.memAddr", memAddr, 32'd0);
      checkOutput("abort.memOp", 32'(memOp), 32'd2);
      checkOutput("abort.memDin", memDin, 32'd0);
      checkOutput("abort.rspValid", 32'(rspValid), 32'd0);
      checkOutput("abort.reqReady", 32'(reqReady), 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("abort.opsIssued", 32'(oplog.size()), 32'd1);
      checkOutput("abort.byte301", 32'(rdb(32'h301)), 32'h0D);
      checkOutput("abort.byte302", 32'(rdb(32'h302)), 32'hBE);
      rstn = 1'b1;
      #1;
      checkOutput("abort.readyAfter", 32'(reqReady), 32'd1);
      applyStimulus("abort.readback", 1'b0, 3'd2, 32'h300, 32'h0, 0, 32'hADBE0D00, 1'b0, 3, 1);
`endif

      for (int t = 0; t < 80; t++) begin
         w = 1'($urandom_range(0, 1));
         o = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         a = 32'h800 + 32'($urandom_range(0, 63));
         d = $urandom;
         h = int'($urandom_range(0, 2));
         refModel(w, o, a, d, ed, ee, el, eo);
         applyStimulus($sformatf("rnd%0d", t), w, o, a, d, h, ed, ee, el, eo);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
